// File: rtl/xoodyak.sv
`timescale 1ns/1ps
// Byte-serial Xoodyak hash core: Cyclist hash mode over Xoodoo[12], one round per clock.
// Message bytes enter while busy=0; the 32-byte digest leaves one byte per valid cycle.
module xoodyak #(
  parameter int HASH_BYTES = 32,
  parameter int RATE       = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  msg,
  input  logic [11:0] msg_len,
  output logic [7:0]  hash,
  output logic [7:0]  hash_len,
  output logic        valid,
  output logic        busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_ABS_PERM = 3'd2;
  localparam logic [2:0] S_FINAL    = 3'd3;
  localparam logic [2:0] S_SQ_PERM  = 3'd4;
  localparam logic [2:0] S_OUT      = 3'd5;

  logic [2:0]   fsm;
  logic [383:0] st;
  logic [4:0]   idx;
  logic [11:0]  remaining;
  logic [7:0]   cd;
  logic [3:0]   rnd;
  logic [3:0]   sq_blk;
  logic [383:0] round_out;
  logic [383:0] ins_msg;
  logic [383:0] pad_final;
  logic [383:0] pad_block;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] round_const(input logic [3:0] r);
    case (r)
      4'd0:    return 32'h058;
      4'd1:    return 32'h038;
      4'd2:    return 32'h3C0;
      4'd3:    return 32'h0D0;
      4'd4:    return 32'h120;
      4'd5:    return 32'h014;
      4'd6:    return 32'h060;
      4'd7:    return 32'h02C;
      4'd8:    return 32'h380;
      4'd9:    return 32'h0F0;
      4'd10:   return 32'h1A0;
      default: return 32'h012;
    endcase
  endfunction

  // Lane 4y+x holds plane y, column x; byte k of the state is bits [8k+7:8k].
  function automatic logic [383:0] xoodoo_round(input logic [383:0] s, input logic [31:0] rc);
    logic [31:0] a [12];
    logic [31:0] b [12];
    logic [31:0] p [4];
    logic [31:0] e [4];
    logic [383:0] r;
    for (int i = 0; i < 12; i++) a[i] = s[32*i +: 32];
    for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[4+x] ^ a[8+x];
    for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    for (int i = 0; i < 12; i++) a[i] = a[i] ^ e[i%4];
    for (int x = 0; x < 4; x++) begin
      b[x]   = a[x];
      b[4+x] = a[4+((x+3)%4)];
      b[8+x] = rotl(a[8+x], 11);
    end
    b[0] = b[0] ^ rc;
    for (int x = 0; x < 4; x++) begin
      a[x]   = b[x]   ^ (~b[4+x] & b[8+x]);
      a[4+x] = b[4+x] ^ (~b[8+x] & b[x]);
      a[8+x] = b[8+x] ^ (~b[x]   & b[4+x]);
    end
    for (int x = 0; x < 4; x++) begin
      b[x]   = a[x];
      b[4+x] = rotl(a[4+x], 1);
      b[8+x] = rotl(a[8+((x+2)%4)], 8);
    end
    for (int i = 0; i < 12; i++) r[32*i +: 32] = b[i];
    return r;
  endfunction

  assign round_out = xoodoo_round(st, round_const(rnd));
  assign ins_msg   = {376'd0, msg} << {idx, 3'b000};
  // In hash mode only bit 0 of Cd reaches the last state byte.
  assign pad_final = ({376'd0, 8'h01} << {idx, 3'b000}) ^ {cd & 8'h01, 376'd0};
  assign pad_block = {cd & 8'h01, 240'd0, 8'h01, 128'd0};

  assign valid = (fsm == S_OUT);
  assign busy  = !(fsm == S_IDLE || fsm == S_LOAD);
  assign hash  = valid ? st[{1'b0, idx, 3'b000} +: 8] : 8'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm       <= S_IDLE;
      st        <= '0;
      idx       <= '0;
      remaining <= '0;
      cd        <= '0;
      rnd       <= '0;
      sq_blk    <= '0;
      hash_len  <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (start) begin
            st        <= '0;
            remaining <= msg_len;
            hash_len  <= HASH_BYTES[7:0];
            idx       <= '0;
            rnd       <= '0;
            sq_blk    <= '0;
            cd        <= 8'h03;
            fsm       <= (msg_len == 12'd0) ? S_FINAL : S_LOAD;
          end
        end
        S_LOAD: begin
          remaining <= remaining - 12'd1;
          if (remaining == 12'd1) begin
            st  <= st ^ ins_msg;
            idx <= idx + 5'd1;
            fsm <= S_FINAL;
          end else if (idx == 5'(RATE - 1)) begin
            // Block padding is folded into the accepting edge so the stall is exactly one permutation.
            st  <= st ^ ins_msg ^ pad_block;
            cd  <= 8'h00;
            idx <= '0;
            rnd <= '0;
            fsm <= S_ABS_PERM;
          end else begin
            st  <= st ^ ins_msg;
            idx <= idx + 5'd1;
          end
        end
        S_ABS_PERM: begin
          st  <= round_out;
          rnd <= rnd + 4'd1;
          if (rnd == 4'd11) fsm <= S_LOAD;
        end
        S_FINAL: begin
          st  <= st ^ pad_final;
          rnd <= '0;
          fsm <= S_SQ_PERM;
        end
        S_SQ_PERM: begin
          st  <= round_out;
          rnd <= rnd + 4'd1;
          if (rnd == 4'd11) begin
            idx <= '0;
            fsm <= S_OUT;
          end
        end
        S_OUT: begin
          idx <= idx + 5'd1;
          if (idx == 5'(RATE - 1)) begin
            idx <= '0;
            if (sq_blk == 4'(HASH_BYTES / RATE - 1)) begin
              fsm <= S_IDLE;
            end else begin
              st     <= st ^ {383'd0, 1'b1};
              sq_blk <= sq_blk + 4'd1;
              rnd    <= '0;
              fsm    <= S_SQ_PERM;
            end
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xoodyak.sv
`timescale 1ns/1ps
// Bench for xoodyak: known digests, back-to-back and random messages against a byte-level Cyclist model.
module tb_xoodyak;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  msg = 8'd0;
  logic [11:0] msg_len = 12'd0;
  logic [7:0]  hash;
  logic [7:0]  hash_len;
  logic        valid;
  logic        busy;

  xoodyak #(.HASH_BYTES(32), .RATE(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .msg(msg), .msg_len(msg_len),
    .hash(hash), .hash_len(hash_len), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  buf_mem [4096];
  logic [7:0]  outq [$];
  logic [7:0]  sb [48];
  logic [11:0] rcs [12] = '{12'h058, 12'h038, 12'h3C0, 12'h0D0, 12'h120, 12'h014,
                            12'h060, 12'h02C, 12'h380, 12'h0F0, 12'h1A0, 12'h012};
  int          kat_len [7] = '{0, 1, 15, 16, 17, 32, 1024};
  logic [255:0] kat [7] = '{
    256'hEA152F2B47BCE24EFB66C479D4ADF17BD324D806E85FF75EE369EE50DC8F8BD1,
    256'h27921F8DDF392894460B70B3ED6C091E6421B7D2147DCD6031D7EFEBAD3030CC,
    256'hDB4C9CFE9D385D8CA329E27AEB495A0816C1AB051A57C231A134082661D71BED,
    256'h9EA695347CDDDFF9BC63ECE30FE231441D581768FE223DD6BD7367094FD216B3,
    256'h20593B39BB6D595019331601244411323F713085BB1A30218C972B96D9B7B7B3,
    256'hCEBE4AFF9EAC2218017DDA5F8207BA830E989187256539BD7D31AE5E94FF0C6E,
    256'hFCC4D63932D98C30CAB597E60B7CCA475BD9FBF984838C5CB5615C949F814615};

  always @(negedge clk) if (valid) outq.push_back(hash);

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Xoodoo[12] on the byte array sb, written over planes a[y][x].
  task automatic permute();
    logic [31:0] a [3][4];
    logic [31:0] p [4];
    logic [31:0] e [4];
    logic [31:0] t [4];
    logic [31:0] b0, b1, b2;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        a[y][x] = {sb[16*y+4*x+3], sb[16*y+4*x+2], sb[16*y+4*x+1], sb[16*y+4*x]};
    for (int r = 0; r < 12; r++) begin
      for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
      for (int x = 0; x < 4; x++) e[x] = rol(p[(x+3)%4], 5) ^ rol(p[(x+3)%4], 14);
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) a[y][x] ^= e[x];
      for (int x = 0; x < 4; x++) t[x] = a[1][x];
      for (int x = 0; x < 4; x++) begin
        a[1][x] = t[(x+3)%4];
        a[2][x] = rol(a[2][x], 11);
      end
      a[0][0] ^= {20'd0, rcs[r]};
      for (int x = 0; x < 4; x++) begin
        b0 = a[0][x]; b1 = a[1][x]; b2 = a[2][x];
        a[0][x] = b0 ^ (~b1 & b2);
        a[1][x] = b1 ^ (~b2 & b0);
        a[2][x] = b2 ^ (~b0 & b1);
      end
      for (int x = 0; x < 4; x++) t[x] = a[2][x];
      for (int x = 0; x < 4; x++) begin
        a[1][x] = rol(a[1][x], 1);
        a[2][x] = rol(t[(x+2)%4], 8);
      end
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        for (int k = 0; k < 4; k++) sb[16*y+4*x+k] = a[y][x][8*k +: 8];
  endtask

  // Cyclist hash: absorb 16-byte blocks (Cd=03 then 00), squeeze two 16-byte blocks.
  task automatic model_hash(input int len, output logic [255:0] dig);
    int pos, blk;
    bit first;
    logic [7:0] cd;
    for (int k = 0; k < 48; k++) sb[k] = 8'd0;
    pos = 0; first = 1'b1; cd = 8'h03;
    do begin
      blk = (len - pos > 16) ? 16 : len - pos;
      if (!first) permute();
      for (int j = 0; j < blk; j++) sb[j] ^= buf_mem[pos+j];
      sb[blk] ^= 8'h01;
      sb[47]  ^= cd & 8'h01;
      cd = 8'h00; pos += blk; first = 1'b0;
    end while (pos < len);
    dig = '0;
    for (int s = 0; s < 2; s++) begin
      if (s == 1) sb[0] ^= 8'h01;
      permute();
      for (int j = 0; j < 16; j++) dig = {dig[247:0], sb[j]};
    end
  endtask

  task automatic run_hash(input int len, input bit inject, output logic [255:0] dig,
                          output int stalls, output int nvalid, output bit timed_out);
    int pos, cyc;
    outq.delete();
    stalls = 0;
    @(posedge clk); #1;
    start = 1'b1; msg_len = 12'(len);
    @(posedge clk); #1;
    start = 1'b0;
    pos = 0; cyc = 0;
    while (pos < len && cyc < 20000) begin
      msg = buf_mem[pos];
      @(negedge clk);
      if (busy) stalls++;
      else pos++;
      @(posedge clk); #1;
      cyc++;
    end
    timed_out = (pos < len);
    cyc = 0;
    while (!(outq.size() >= 32 && !busy) && cyc < 400) begin
      start = inject && (cyc == 3);
      if (inject) msg_len = 12'd5;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 400) timed_out = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    nvalid = outq.size();
    dig = '0;
    for (int j = 0; j < 32 && j < outq.size(); j++) dig = {dig[247:0], outq[j]};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] got, exp_d;
    int st, nv, len;
    bit to;

    for (int i = 0; i < 4096; i++) buf_mem[i] = 8'(i);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_valid", 256'(valid), 256'd0);
    check("rst_hash", 256'(hash), 256'd0);
    check("rst_hash_len", 256'(hash_len), 256'd0);
    resetn = 1'b1;

    for (int n = 0; n < 7; n++) begin
      run_hash(kat_len[n], 1'b0, got, st, nv, to);
      $display("kat len=%0d digest=%h valid_bytes=%0d stalls=%0d", kat_len[n], got, nv, st);
      check($sformatf("kat_len%0d", kat_len[n]), got, kat[n]);
      check($sformatf("kat_nvalid%0d", kat_len[n]), 256'(nv), 256'd32);
      check($sformatf("kat_stalls%0d", kat_len[n]), 256'(st),
            256'((kat_len[n] == 0) ? 0 : 12 * ((kat_len[n] - 1) / 16)));
      check($sformatf("kat_timeout%0d", kat_len[n]), 256'(to), 256'd0);
      check($sformatf("kat_hash_len%0d", kat_len[n]), 256'(hash_len), 256'd32);
    end

    for (int n = 0; n < 40; n++) begin
      model_hash(n, exp_d);
      run_hash(n, n[0], got, st, nv, to);
      $display("b2b len=%0d start_while_busy=%0d digest=%h valid_bytes=%0d", n, n[0], got, nv);
      check($sformatf("b2b_len%0d", n), got, exp_d);
      check($sformatf("b2b_nvalid%0d", n), 256'(nv), 256'd32);
      check($sformatf("b2b_timeout%0d", n), 256'(to), 256'd0);
    end

    for (int it = 0; it < 6; it++) begin
      len = int'($urandom_range(0, 300));
      for (int j = 0; j < len; j++) buf_mem[j] = 8'($urandom);
      model_hash(len, exp_d);
      run_hash(len, 1'b1, got, st, nv, to);
      $display("rand len=%0d digest=%h valid_bytes=%0d stalls=%0d", len, got, nv, st);
      check($sformatf("rand_len%0d", len), got, exp_d);
      check($sformatf("rand_nvalid%0d", len), 256'(nv), 256'd32);
      check($sformatf("rand_stalls%0d", len), 256'(st), 256'((len == 0) ? 0 : 12 * ((len - 1) / 16)));
    end

    // Abort in the middle of a long message, then hash again from scratch.
    for (int i = 0; i < 4096; i++) buf_mem[i] = 8'(i);
    @(posedge clk); #1;
    start = 1'b1; msg_len = 12'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin msg = 8'($urandom); @(posedge clk); #1; end
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    $display("midreset busy=%0d valid=%0d hash_len=%0d", busy, valid, hash_len);
    check("midrst_busy", 256'(busy), 256'd0);
    check("midrst_valid", 256'(valid), 256'd0);
    check("midrst_hash_len", 256'(hash_len), 256'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    model_hash(5, exp_d);
    run_hash(5, 1'b0, got, st, nv, to);
    $display("post_reset len=5 digest=%h valid_bytes=%0d", got, nv);
    check("post_reset_len5", got, exp_d);
    check("post_reset_nvalid", 256'(nv), 256'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
